// File: rtl/hdlc_stuff_tx.sv
// hdlc_stuff_tx: HDLC-style serial frame transmitter.
// Takes bytes over valid/ready and shifts them out LSB-first, one bit per clk.
// Each frame is wrapped in FLAG bytes. A 0 is inserted after every STUFF_RUN
// consecutive payload 1s so that payload can never look like a flag. If the
// next byte is missing at a byte boundary, ABORT_LEN ones go out instead.
// Every serial-side output is registered: a bit shows on bit_out one cycle
// after the state that produces it.
module hdlc_stuff_tx #(
    parameter int         STUFF_RUN = 5,
    parameter int         ABORT_LEN = 7,
    parameter logic [7:0] FLAG      = 8'h7E
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    input  logic       data_last,
    output logic       data_ready,
    output logic       bit_out,
    output logic       busy,
    output logic       stuffed,
    output logic       frame_done,
    output logic       underrun
);

    localparam int OW = $clog2(STUFF_RUN + 1);
    localparam int AW = $clog2(ABORT_LEN + 1);

    typedef enum logic [2:0] {
        IDLE,
        OPEN_FLAG,
        SHIFT,
        STUFF,
        CLOSE_FLAG,
        ABORT
    } state_t;

    state_t        state_q;
    logic [7:0]    shreg_q;       // byte currently being serialized
    logic          last_q;        // shreg_q is the final byte of the frame
    logic [2:0]    idx_q;         // bit index within payload byte or flag
    logic [OW-1:0] ones_q;        // run of consecutive payload 1s
    logic [AW-1:0] abort_cnt_q;   // abort bits already issued
    logic          close_pend_q;  // the pending STUFF bit is followed by CLOSE_FLAG

    logic          bit_out_q;
    logic          busy_q;
    logic          stuffed_q;
    logic          frame_done_q;
    logic          underrun_q;

    logic          cur_bit;
    logic [OW-1:0] ones_d;
    logic          stuff_hit;
    logic          byte_end;
    logic          accept;

    // Payload bit for this cycle and the run length it produces.
    always_comb begin
        cur_bit   = shreg_q[idx_q];
        ones_d    = cur_bit ? (ones_q + OW'(1)) : '0;
        stuff_hit = (ones_d == OW'(STUFF_RUN));
        byte_end  = (idx_q == 3'd7);
    end

    // Ready in IDLE, and in the bit-7 SHIFT cycle of a byte that is not last.
    always_comb begin
        data_ready = 1'b0;
        if (!rst) begin
            if (state_q == IDLE)
                data_ready = 1'b1;
            else if (state_q == SHIFT && byte_end && !last_q)
                data_ready = 1'b1;
        end
        accept = data_valid && data_ready;
    end

    // Frame sequencer. Each non-IDLE state registers exactly one line bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            last_q       <= 1'b0;
            idx_q        <= '0;
            ones_q       <= '0;
            abort_cnt_q  <= '0;
            close_pend_q <= 1'b0;
            bit_out_q    <= 1'b1;
            busy_q       <= 1'b0;
            stuffed_q    <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            // Line idles high; pulses default low.
            bit_out_q    <= 1'b1;
            busy_q       <= (state_q != IDLE);
            stuffed_q    <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (accept) begin
                        shreg_q <= data_in;
                        last_q  <= data_last;
                        idx_q   <= '0;
                        state_q <= OPEN_FLAG;
                    end
                end

                OPEN_FLAG: begin
                    bit_out_q <= FLAG[idx_q];
                    if (idx_q == 3'd7) begin
                        idx_q   <= '0;
                        ones_q  <= '0;
                        state_q <= SHIFT;
                    end else begin
                        idx_q <= idx_q + 3'd1;
                    end
                end

                SHIFT: begin
                    bit_out_q    <= cur_bit;
                    ones_q       <= ones_d;
                    close_pend_q <= 1'b0;
                    if (!byte_end) begin
                        idx_q   <= idx_q + 3'd1;
                        state_q <= stuff_hit ? STUFF : SHIFT;
                    end else if (last_q) begin
                        // Closing flag follows, after the stuff bit if one is owed.
                        idx_q        <= '0;
                        close_pend_q <= 1'b1;
                        state_q      <= stuff_hit ? STUFF : CLOSE_FLAG;
                    end else if (accept) begin
                        // Next byte loads now so it follows with no gap.
                        shreg_q <= data_in;
                        last_q  <= data_last;
                        idx_q   <= '0;
                        state_q <= stuff_hit ? STUFF : SHIFT;
                    end else begin
                        // Source ran dry: the abort replaces any owed stuff bit.
                        idx_q       <= '0;
                        abort_cnt_q <= '0;
                        state_q     <= ABORT;
                    end
                end

                STUFF: begin
                    bit_out_q <= 1'b0;
                    stuffed_q <= 1'b1;
                    ones_q    <= '0;
                    state_q   <= close_pend_q ? CLOSE_FLAG : SHIFT;
                end

                CLOSE_FLAG: begin
                    bit_out_q <= FLAG[idx_q];
                    if (idx_q == 3'd7) begin
                        frame_done_q <= 1'b1;
                        idx_q        <= '0;
                        state_q      <= IDLE;
                    end else begin
                        idx_q <= idx_q + 3'd1;
                    end
                end

                ABORT: begin
                    bit_out_q  <= 1'b1;
                    underrun_q <= (abort_cnt_q == '0);
                    if (abort_cnt_q == AW'(ABORT_LEN - 1)) begin
                        abort_cnt_q <= '0;
                        state_q     <= IDLE;
                    end else begin
                        abort_cnt_q <= abort_cnt_q + AW'(1);
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign bit_out    = bit_out_q;
    assign busy       = busy_q;
    assign stuffed    = stuffed_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_hdlc_stuff_tx.sv
// Bench for hdlc_stuff_tx. A frame-level model expands each frame into its
// line bits (flags, LSB-first payload, inserted zeros, abort run). These bits
// are laid onto a cycle timeline together with the input stimulus. The DUT is
// then compared against that timeline on every cycle.
module tb_hdlc_stuff_tx;
    localparam int NC = 4096;
    localparam logic [7:0] FLAGB = 8'h7E;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       data_valid, data_last;
    logic       data_ready, bit_out, busy, stuffed, frame_done, underrun;

    always #5 clk = ~clk;

    hdlc_stuff_tx dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .data_last(data_last), .data_ready(data_ready), .bit_out(bit_out),
        .busy(busy), .stuffed(stuffed), .frame_done(frame_done), .underrun(underrun)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct { bit b; bit st; bit fd; bit ur; bit b7; int k; } rec_t;
    rec_t mq[$];

    // Expected outputs per cycle, plus the stimulus to drive in that cycle.
    bit         e_bit [NC+2];
    bit         e_busy[NC+2];
    bit         e_st  [NC+2];
    bit         e_fd  [NC+2];
    bit         e_ur  [NC+2];
    bit         e_b7  [NC+2];
    bit         s_v   [NC];
    logic [7:0] s_d   [NC];
    bit         s_l   [NC];

    int cyc    = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic void push(bit b, bit st, bit fd, bit ur, bit b7, int k);
        rec_t r;
        r.b = b; r.st = st; r.fd = fd; r.ur = ur; r.b7 = b7; r.k = k;
        mq.push_back(r);
    endfunction

    // Line bits of one frame. ab_k >= 0 means the byte after ab_k never arrives.
    function automatic void gen_frame(input logic [7:0] bytes[8], input int n, input int ab_k);
        int ones;
        bit b;
        mq.delete();
        ones = 0;
        for (int i = 0; i < 8; i++) push(FLAGB[i], 0, 0, 0, 0, 0);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 8; i++) begin
                b = bytes[k][i];
                push(b, 0, 0, 0, (i == 7 && k != n - 1), k);
                ones = b ? ones + 1 : 0;
                if (k == ab_k && i == 7) begin
                    for (int a = 0; a < 7; a++) push(1, 0, 0, (a == 0), 0, 0);
                    return;
                end
                if (ones == 5) begin
                    push(0, 1, 0, 0, 0, 0);
                    ones = 0;
                end
            end
        end
        for (int i = 0; i < 8; i++) push(FLAGB[i], 0, (i == 7), 0, 0, 0);
    endfunction

    function automatic logic [63:0] pack_bits();
        logic [63:0] p;
        p = '0;
        foreach (mq[j]) p = {p[62:0], mq[j].b};
        return p;
    endfunction

    function automatic int count_st();
        int c;
        c = 0;
        foreach (mq[j]) c += int'(mq[j].st);
        return c;
    endfunction

    function automatic void clear_tl();
        for (int c = 0; c < NC + 2; c++) begin
            e_bit[c] = 1; e_busy[c] = 0; e_st[c] = 0; e_fd[c] = 0; e_ur[c] = 0; e_b7[c] = 0;
        end
        for (int c = 0; c < NC; c++) begin
            s_v[c] = 0; s_d[c] = 8'h00; s_l[c] = 0;
        end
    endfunction

    // Place a frame whose first byte is offered in cycle h.
    // Returns the cycle in which the DUT is idle again.
    function automatic int place(input int h, input logic [7:0] bytes[8], input int n, input int ab_k);
        int c, rc, kk, acc;
        gen_frame(bytes, n, ab_k);
        s_v[h] = 1; s_d[h] = bytes[0]; s_l[h] = (n == 1);
        acc = h;
        for (int j = 0; j < mq.size(); j++) begin
            c = h + 2 + j;
            e_bit[c] = mq[j].b; e_busy[c] = 1; e_st[c] = mq[j].st;
            e_fd[c] = mq[j].fd; e_ur[c] = mq[j].ur; e_b7[c] = mq[j].b7;
            if (mq[j].b7) begin
                rc = c - 1;
                kk = mq[j].k;
                if (kk != ab_k) begin
                    // Valid may wander while ready is low; it must be high at the boundary.
                    for (int cc = acc + 1; cc < rc; cc++) begin
                        s_v[cc] = bit'($urandom_range(0, 1));
                        s_d[cc] = bytes[kk+1]; s_l[cc] = (kk + 1 == n - 1);
                    end
                    s_v[rc] = 1; s_d[rc] = bytes[kk+1]; s_l[rc] = (kk + 1 == n - 1);
                    acc = rc;
                end
            end
        end
        return h + 1 + mq.size();
    endfunction

    // Per-cycle comparison against the timeline.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("bit_out",    bit_out,    e_bit[cyc]);
            chk("busy",       busy,       e_busy[cyc]);
            chk("stuffed",    stuffed,    e_st[cyc]);
            chk("frame_done", frame_done, e_fd[cyc]);
            chk("underrun",   underrun,   e_ur[cyc]);
            chk("data_ready", data_ready, (!e_busy[cyc+1] || e_b7[cyc+1]));
        end
    end

    task automatic run_tl(input int n);
        data_valid = 0; data_in = 0; data_last = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        cyc = 0;
        data_valid = s_v[0]; data_in = s_d[0]; data_last = s_l[0];
        chk_en = 1;
        for (int c = 1; c < n; c++) begin
            @(posedge clk);
            #1;
            cyc = c;
            data_valid = s_v[c]; data_in = s_d[c]; data_last = s_l[c];
        end
        @(posedge clk);
        #1;
        chk_en = 0;
        data_valid = 0; data_in = 0; data_last = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  bb [8];
        logic [63:0] expv;
        int h, L, n, ab;

        rst = 1; data_in = 0; data_valid = 0; data_last = 0;
        foreach (bb[i]) bb[i] = 8'h00;

        // Hand-computed expectations that pin the model.
        bb[0] = 8'h00; gen_frame(bb, 1, -1);
        chk("model_00_len", mq.size(), 24);
        chk("model_00_bits", pack_bits(), 64'h7E007E);
        chk("model_00_st", count_st(), 0);
        chk("model_00_fd", mq[23].fd, 1);
        bb[0] = 8'hFF; gen_frame(bb, 1, -1);
        expv = {8'b01111110, 9'b111110111, 8'b01111110};
        chk("model_FF_len", mq.size(), 25);
        chk("model_FF_bits", pack_bits(), expv);
        chk("model_FF_st", mq[13].st, 1);
        bb[0] = 8'h3E; gen_frame(bb, 1, -1);
        expv = {8'b01111110, 9'b011111000, 8'b01111110};
        chk("model_3E_bits", pack_bits(), expv);
        chk("model_3E_st", count_st(), 1);
        bb[0] = 8'hF0; bb[1] = 8'h0F; gen_frame(bb, 2, -1);
        expv = {8'b01111110, 17'b00001111101110000, 8'b01111110};
        chk("model_F00F_len", mq.size(), 33);
        chk("model_F00F_bits", pack_bits(), expv);
        bb[0] = 8'h00; bb[1] = 8'h55; gen_frame(bb, 2, 0);
        expv = {8'b01111110, 8'b00000000, 7'b1111111};
        chk("model_abort_len", mq.size(), 23);
        chk("model_abort_bits", pack_bits(), expv);
        chk("model_abort_ur", mq[16].ur, 1);

        // Phase 1: directed frames, some back-to-back, then random ones.
        clear_tl();
        bb[0] = 8'h00;                L = place(2, bb, 1, -1);
        bb[0] = 8'hFF;                L = place(L, bb, 1, -1);
        bb[0] = 8'h3E;                L = place(L + 1, bb, 1, -1);
        bb[0] = 8'hF0; bb[1] = 8'h0F; L = place(L, bb, 2, -1);
        bb[0] = 8'h00; bb[1] = 8'h55; L = place(L + 2, bb, 2, 0);
        bb[0] = 8'hFF; bb[1] = 8'hFF; bb[2] = 8'hFF; L = place(L, bb, 3, -1);
        bb[0] = 8'hF8; bb[1] = 8'h01; L = place(L, bb, 2, 0);
        while (L < NC - 150) begin
            n = $urandom_range(1, 5);
            for (int i = 0; i < 8; i++)
                bb[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom | $urandom);
            ab = (n > 1 && $urandom_range(0, 4) == 0) ? $urandom_range(0, n - 2) : -1;
            h = L + $urandom_range(0, 3);
            L = place(h, bb, n, ab);
        end
        run_tl(L + 5);

        // Phase 2: reset in the middle of the payload.
        data_in = 8'hFF; data_last = 1; data_valid = 1;
        @(posedge clk);
        #1;
        data_valid = 0;
        repeat (11) @(posedge clk);
        #3;
        chk("pre_rst_busy", busy, 1);
        rst = 1;
        #1;
        chk("rst_bit_out", bit_out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ready", data_ready, 0);
        chk("rst_stuffed", stuffed, 0);
        chk("rst_frame_done", frame_done, 0);

        // Phase 3: clean frames after the reset.
        clear_tl();
        bb[0] = 8'hA5; bb[1] = 8'h3C; bb[2] = 8'hFF; L = place(1, bb, 3, -1);
        bb[0] = 8'h7E;                L = place(L, bb, 1, -1);
        run_tl(L + 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
